// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Imported by the arbiter top and its winner-select helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned MAX_D_STREAK_DEF = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store.
// Load/store wins unless its streak has starved a pending fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic [3:0] d_streak,
  output logic       sel_valid,
  output logic       sel_d
);

  localparam logic [3:0] LIMIT = 4'(MAX_D_STREAK);

  assign sel_valid = i_req | d_req;

  always_comb begin
    sel_d = 1'b0;
    unique case (1'b1)
      (d_req && !i_req): sel_d = 1'b1;
      (i_req && !d_req): sel_d = 1'b0;
      (i_req && d_req):  sel_d = (d_streak < LIMIT);
      default:           sel_d = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D).
// One outstanding req/gnt/rvalid transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_done,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            owner
);

  localparam int unsigned BW = DW / 8;

  state_e          state_q, state_d;
  logic [3:0]      d_streak_q, d_streak_d;
  logic            owner_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [BW-1:0]   mem_be_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic            sel_valid;
  logic            sel_d;
  logic            latch;
  logic            capture;

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .d_streak (d_streak_q),
    .sel_valid(sel_valid),
    .sel_d    (sel_d)
  );

  always_comb begin
    state_d    = state_q;
    d_streak_d = d_streak_q;
    latch      = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          latch   = 1'b1;
          state_d = REQ;
          // Only a D win that bypasses a waiting fetch counts.
          if (sel_d && i_req) begin
            if (d_streak_q != 4'hF) begin
              d_streak_d = d_streak_q + 4'd1;
            end
          end else begin
            d_streak_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      d_streak_q  <= '0;
      owner_q     <= OWN_I;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
      if (latch) begin
        if (sel_d) begin
          owner_q     <= OWN_D;
          mem_we_q    <= d_we;
          mem_addr_q  <= d_addr;
          mem_wdata_q <= d_wdata;
          mem_be_q    <= d_be;
        end else begin
          owner_q     <= OWN_I;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= i_addr;
          mem_wdata_q <= '0;
          mem_be_q    <= {BW{1'b1}};
        end
      end
      if (capture) begin
        if (owner_q == OWN_D) d_rdata_q <= mem_rdata;
        else                  i_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign i_done    = (state_q == DONE) && (owner_q == OWN_I);
  assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
  assign owner     = owner_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder checks
// issued commands, a monitor checks every done pulse against a queue.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_done, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic        busy, owner;

  logic        resp_gnt, resp_rvalid, man_gnt, man_rvalid;
  logic [31:0] resp_rdata;

  assign mem_gnt    = resp_gnt | man_gnt;
  assign mem_rvalid = resp_rvalid | man_rvalid;
  assign mem_rdata  = resp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  // cmd layout: {req, owner, we, be[3:0], addr[31:0], wdata[31:0]}
  typedef struct {
    logic [70:0] cmd;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
  } cmd_t;

  typedef struct {
    logic        own;
    logic [31:0] rdata;
  } exp_t;

  cmd_t cmd_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [70:0] icmd(input logic [31:0] a);
    return {1'b1, OWN_I, 1'b0, 4'hF, a, 32'h0};
  endfunction

  function automatic logic [70:0] dcmd(input logic we, input logic [31:0] a,
                                       input logic [31:0] wd,
                                       input logic [3:0] be);
    return {1'b1, OWN_D, we, be, a, wd};
  endfunction

  task automatic issue(input logic [70:0] c, input int gd, input int rd,
                       input logic [31:0] data, input bit exp_done);
    cmd_t ce;
    exp_t ee;
    ce.cmd = c; ce.gnt_dly = gd; ce.rv_dly = rd; ce.rdata = data;
    cmd_q.push_back(ce);
    if (exp_done) begin
      ee.own = c[69]; ee.rdata = data;
      exp_q.push_back(ee);
    end
  endtask

  function automatic logic [159:0] outs();
    return 160'({i_done, d_done, i_rdata, d_rdata, mem_req, mem_we,
                 mem_addr, mem_wdata, mem_be, busy, owner});
  endfunction

  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        n = k;
        return;
      end
    end
  endtask

  // Memory responder: checks the command while it is offered.
  initial begin
    cmd_t c;
    resp_gnt = 1'b0; resp_rvalid = 1'b0; resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_req", 160'(mem_req), 160'd0);
        end else begin
          c = cmd_q.pop_front();
          for (int k = 0; k <= c.gnt_dly; k++) begin
            if (k > 0) @(negedge clk);
            chk("cmd", 160'({mem_req, owner, mem_we, mem_be,
                             mem_addr, mem_wdata}), 160'(c.cmd));
          end
          resp_gnt = 1'b1;
          @(negedge clk);
          resp_gnt = 1'b0;
          repeat (c.rv_dly) @(negedge clk);
          resp_rvalid = 1'b1;
          resp_rdata  = c.rdata;
          @(negedge clk);
          resp_rvalid = 1'b0;
        end
      end
    end
  end

  // Done monitor
  always @(negedge clk) begin
    exp_t e;
    if (i_done === 1'b1 || d_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 160'({i_done, d_done}), 160'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done", 160'({d_done, i_done, owner, d_done ? d_rdata : i_rdata}),
            160'({e.own, !e.own, e.own, e.rdata}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    man_gnt = 0; man_rvalid = 0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 160'd0);
    reset = 1'b1;
    @(negedge clk);

    // fetch only, minimum latency
    i_addr = 32'h100;
    issue(icmd(32'h100), 0, 0, 32'h00500093, 1);
    i_req = 1;
    wait_done(10, n);
    chk("i_lat", 160'(n), 160'd3);
    chk("i_rdata", 160'(i_rdata), 160'h00500093);
    i_req = 0;
    repeat (2) @(negedge clk);

    // store with gnt held off three cycles
    d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    issue(dcmd(1'b1, 32'h2000, 32'hDEADBEEF, 4'h3), 3, 0, 32'hCAFE0001, 1);
    d_req = 1;
    wait_done(20, n);
    chk("d_lat", 160'(n), 160'd6);
    chk("d_only", 160'({i_done, d_done}), 160'b01);
    d_req = 0;
    repeat (2) @(negedge clk);

    // both held high: D,D,D,D,I repeating
    i_addr = 32'h400;
    d_we = 0; d_addr = 32'h3000; d_wdata = 32'h11112222; d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        issue(icmd(32'h400), 0, 0, 32'hA0000000 + 32'(k), 1);
      else
        issue(dcmd(1'b0, 32'h3000, 32'h11112222, 4'hF), 0, 0,
              32'hA0000000 + 32'(k), 1);
    end
    i_req = 1; d_req = 1;
    for (int k = 0; k < 10; k++) begin
      wait_done(10, n);
      chk("stream_lat", 160'(n), (k == 0) ? 160'd3 : 160'd4);
    end
    i_req = 0; d_req = 0;
    repeat (2) @(negedge clk);

    // D arrives while fetch is in RESP
    i_addr = 32'h700; d_addr = 32'h3100;
    issue(icmd(32'h700), 0, 1, 32'h00000077, 1);
    issue(dcmd(1'b0, 32'h3100, 32'h11112222, 4'hF), 0, 0, 32'h00000088, 1);
    i_req = 1;
    repeat (2) @(negedge clk);
    chk("t4_resp", 160'({busy, mem_req}), 160'b10);
    d_req = 1;
    wait_done(10, n);
    chk("t4_i_lat", 160'(n), 160'd2);
    chk("t4_i_first", 160'({i_done, d_done}), 160'b10);
    i_req = 0;
    @(negedge clk);
    chk("t4_idle", 160'(busy), 160'd0);
    @(negedge clk);
    chk("t4_d_sel", 160'({mem_req, owner}), 160'b11);
    wait_done(10, n);
    chk("t4_d_lat", 160'(n), 160'd2);
    d_req = 0;
    chk("t4_streak", 160'(dut.d_streak_q), 160'd0);
    repeat (2) @(negedge clk);

    // stray rvalid while idle
    man_rvalid = 1;
    @(negedge clk);
    man_rvalid = 0;
    chk("stray_rv", 160'({busy, mem_req}), 160'd0);
    @(negedge clk);
    chk("stray_rv2", 160'({busy, mem_req}), 160'd0);

    // stray gnt while in RESP
    i_addr = 32'h600;
    issue(icmd(32'h600), 0, 3, 32'h00000066, 1);
    i_req = 1;
    repeat (2) @(negedge clk);
    man_gnt = 1;
    @(negedge clk);
    man_gnt = 0;
    chk("stray_gnt", 160'({busy, mem_req}), 160'b10);
    wait_done(10, n);
    chk("stray_gnt_lat", 160'(n), 160'd3);
    i_req = 0;
    repeat (2) @(negedge clk);

    // async reset in RESP; late rvalid must be dropped
    i_addr = 32'h500;
    issue(icmd(32'h500), 0, 4, 32'h00000055, 0);
    i_req = 1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", outs(), 160'd0);
    i_req = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset", 160'({busy, mem_req, i_rdata}), 160'd0);

    chk("exp_q_empty", 160'(exp_q.size()), 160'd0);
    chk("cmd_q_empty", 160'(cmd_q.size()), 160'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the CPU's single unified memory port between instruction fetch (I) and load/store (D). It sits between the fetch/LSU side of the core and the memory, and allows one outstanding transaction at a time. Each transaction runs a req/gnt/rvalid handshake with the memory. D has priority, and a streak limit guarantees fetch progress.

## Interface
- AW, 32, address width
- DW, 32, data width (byte-enable width = DW/8)
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending (legal 1..15)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held high until i_done
- i_addr  in  AW  fetch address
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DW  fetched word
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_done  out  1  one-cycle pulse: data access complete, d_rdata valid for loads
- d_rdata  out  DW  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  response valid; exactly one per accepted request, loads and stores alike
- mem_rdata  in  DW  response data
- busy  out  1  transaction in flight (state != IDLE)
- owner  out  1  0 = I, 1 = D; owner of the current or last transaction

## Operation
- FSM states and transitions:
  - IDLE: if any request is pending, pick a winner, latch its command into the mem_* registers, and go to REQ.
  - REQ: mem_req = 1. Stay until mem_gnt, then go to RESP.
  - RESP: wait for mem_rvalid. When it arrives, register mem_rdata and go to DONE.
  - DONE: pulse the owner's done signal, then go to IDLE.
- Winner selection in IDLE:
  - Only d_req: D wins.
  - Only i_req: I wins.
  - Both pending: D wins if d_streak < MAX_D_STREAK; otherwise I wins.
- d_streak (4-bit) update when a winner is chosen:
  - D wins while i_req is high: d_streak increments, saturating at 15.
  - I wins: d_streak clears.
  - D wins with i_req low: d_streak clears.
- I transactions are forced to mem_we = 0, mem_be = all ones, mem_wdata = 0.
- Command fields are latched at selection. Requester changes after that are ignored until the done pulse.
- i_rdata and d_rdata are registered and hold their value until the next completion for that port. For D stores, d_rdata is loaded with mem_rdata, whose value is don't-care.
- mem_rvalid outside RESP is ignored. mem_gnt outside REQ is ignored.
- A requester must not drop req before its done pulse. If it does, the transaction still completes and the done pulse is still issued.

## Timing
- Reset value of every output is 0: i_done, d_done, i_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, owner. Reset also returns the FSM to IDLE and clears d_streak.
- Reset is asynchronous mid-transaction. A memory response still owed from before reset is dropped, because rvalid is ignored in IDLE.
- Minimum latency: req sampled high in cycle 0 → mem_req in cycle 1 → gnt in cycle 1 → rvalid in cycle 2 → done in cycle 3.
- Back-to-back transactions: the next selection happens in the cycle after DONE. Peak throughput is one transaction per 4 cycles.
- mem_rvalid is never in the same cycle as mem_gnt for the same request; it arrives at the earliest in the following cycle.
- A requester may see its req still high in the cycle of its own done pulse. It is not re-sampled until IDLE, so a new request is taken only if the requester keeps req high after done.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, RESP, DONE};
  - owner encoding constants OWN_I = 0 and OWN_D = 1;
  - the default MAX_D_STREAK.
- One combinational sub-module, mem_arb_pick, with inputs i_req, d_req, d_streak and MAX_D_STREAK, and outputs sel_valid and sel_d. The FSM, registers and counter live in the top level.

## Test plan
- I only, i_addr = 0x100, gnt same cycle, rvalid one cycle later with 0x00500093 → mem_addr = 0x100 with mem_we = 0 and mem_be = 0xF; i_done in cycle 3; i_rdata = 0x00500093.
- D store, d_addr = 0x2000, d_wdata = 0xDEADBEEF, d_be = 0x3, gnt delayed 3 cycles → mem_req and all command fields stable for 4 cycles; d_done 2 cycles after gnt; i_done stays 0.
- I and D held continuously high, MAX_D_STREAK = 4 → grant order D,D,D,D,I,D,D,D,D,I; owner matches each transaction.
- d_req rises while an I transaction is in RESP → I completes first; D is selected in the cycle after i_done; d_streak stays 0.
- Reset asserted in RESP, then rvalid arrives after reset release → all outputs 0 immediately on reset assertion; no done pulse; FSM in IDLE.
- Stray mem_rvalid pulse while in IDLE, and mem_gnt pulse while in RESP → no state change, no done pulse.
